// File: rtl/yarp_encode.sv
// RV32I instruction encoder: packs per-field requests into 32-bit words behind a
// single registered valid/ready stage, tagging each word with a sequential address.
module yarp_encode #(
    parameter int unsigned         ADDR_W    = 10,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        fmt_i,
    input  logic [6:0]        op_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    input  logic              addr_clr_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [31:0] enc_word;
    logic        enc_err;
    logic        imm_bad;
    logic        accept;
    logic        out_hs;

    // Field packing and range checks; an out-of-range word is still packed from truncated fields.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        enc_word = '0;
        imm_bad  = 1'b0;
        enc_err  = 1'b0;
        case (fmt_i)
            FMT_R: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
            FMT_I: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                imm_bad  = imm_i[31:11] != {21{imm_i[31]}};
            end
            FMT_S: begin
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
                imm_bad  = imm_i[31:11] != {21{imm_i[31]}};
            end
            FMT_B: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], op_i};
                imm_bad  = (imm_i[31:12] != {20{imm_i[31]}}) | imm_i[0];
            end
            FMT_U: begin
                enc_word = {imm_i[31:12], rd_i, op_i};
                imm_bad  = imm_i[11:0] != 12'd0;
            end
            FMT_J: begin
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                imm_bad  = (imm_i[31:20] != {12{imm_i[31]}}) | imm_i[0];
            end
            default: imm_bad = 1'b1;
        endcase
        enc_err = imm_bad | (op_i[1:0] != 2'b11);
        if (fmt_i > FMT_J) begin
            enc_word = '0;
            enc_err  = 1'b1;
        end
    end

    assign req_ready_o = ~valid_q | instr_ready_i;
    assign accept      = req_valid_i & req_ready_o;
    assign out_hs      = valid_q & instr_ready_i;

    always_comb begin
        valid_d   = accept | (valid_q & ~instr_ready_i);
        instr_d   = accept ? enc_word : instr_q;
        err_d     = accept ? enc_err  : err_q;
        err_cnt_d = err_cnt_q;
        if (out_hs && err_q && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        // Clear beats a simultaneous handshake and re-tags a held word.
        if (addr_clr_i) begin
            addr_d = BASE_ADDR;
        end else if (out_hs) begin
            addr_d = addr_q + ADDR_W'(1);
        end else begin
            addr_d = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            err_q     <= 1'b0;
            addr_q    <= BASE_ADDR;
            err_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign err_o         = err_q;
    assign instr_addr_o  = addr_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_yarp_encode.sv
// Self-checking bench for yarp_encode: directed encodings and handshake corners, then
// randomized traffic against a behavioural model built from range arithmetic and shifts.
module tb_yarp_encode;

    localparam int unsigned ADDR_W = 2;

    logic              clk;
    logic              reset;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        fmt_i;
    logic [6:0]        op_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [31:0]       imm_i;
    logic              addr_clr_i;
    logic              instr_valid_o;
    logic              instr_ready_i;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] instr_addr_o;
    logic              err_o;
    logic [7:0]        err_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of what the output side should show.
    bit        m_valid;
    bit [31:0] m_instr;
    bit        m_err;
    int        m_addr;
    int        m_cnt;

    yarp_encode #(.ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .fmt_i         (fmt_i),
        .op_i          (op_i),
        .rd_i          (rd_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .imm_i         (imm_i),
        .addr_clr_i    (addr_clr_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_addr_o  (instr_addr_o),
        .err_o         (err_o),
        .err_cnt_o     (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference encoder: immediates range-checked as signed integers, fields placed by shifts.
    function automatic void ref_encode(input bit [2:0] fmt, input bit [31:0] op, input bit [31:0] rd,
                                       input bit [31:0] rs1, input bit [31:0] rs2, input bit [31:0] f3,
                                       input bit [31:0] f7, input bit [31:0] imm,
                                       output bit [31:0] w, output bit e);
        int  s;
        bit  op_bad;
        bit  odd;
        s      = int'(imm);
        op_bad = (op % 4) != 3;
        odd    = (imm % 2) != 0;
        w = 0;
        e = 1;
        case (fmt)
            3'd0: begin
                w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                e = op_bad;
            end
            3'd1: begin
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                e = op_bad || s < -2048 || s > 2047;
            end
            3'd2: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                  | ((imm & 32'h1F) << 7) | op;
                e = op_bad || s < -2048 || s > 2047;
            end
            3'd3: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                  | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                  | (((imm >> 11) & 1) << 7) | op;
                e = op_bad || s < -4096 || s > 4095 || odd;
            end
            3'd4: begin
                w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
                e = op_bad || (imm % 4096) != 0;
            end
            3'd5: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
                e = op_bad || s < -(1 << 20) || s > (1 << 20) - 1 || odd;
            end
            default: begin
                w = 0;
                e = 1;
            end
        endcase
    endfunction

    // One clock: check ready, advance the model at the edge, compare outputs just after it.
    task automatic cycle();
        bit        acc, hs;
        bit [31:0] w;
        bit        e;
        #1;
        check("req_ready", 32'(req_ready_o), 32'(!m_valid || instr_ready_i));
        acc = req_valid_i && (!m_valid || instr_ready_i);
        hs  = m_valid && instr_ready_i;
        ref_encode(fmt_i, 32'(op_i), 32'(rd_i), 32'(rs1_i), 32'(rs2_i), 32'(funct3_i),
                   32'(funct7_i), imm_i, w, e);
        @(posedge clk);
        if (reset) begin
            m_valid = 0;
            m_instr = 0;
            m_err   = 0;
            m_addr  = 0;
            m_cnt   = 0;
        end else begin
            if (hs && m_err && m_cnt < 255) m_cnt++;
            if (addr_clr_i)  m_addr = 0;
            else if (hs)     m_addr = (m_addr + 1) % (1 << ADDR_W);
            if (acc) begin
                m_valid = 1;
                m_instr = w;
                m_err   = e;
            end else if (hs) begin
                m_valid = 0;
            end
        end
        #1;
        check("valid", 32'(instr_valid_o), 32'(m_valid));
        check("addr", 32'(instr_addr_o), 32'(m_addr));
        check("err_cnt", 32'(err_cnt_o), 32'(m_cnt));
        if (m_valid) begin
            check("instr", instr_o, m_instr);
            check("err", 32'(err_o), 32'(m_err));
        end
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        req_valid_i = 1'b1;
        fmt_i       = fmt;
        op_i        = op;
        rd_i        = rd;
        rs1_i       = rs1;
        rs2_i       = rs2;
        funct3_i    = f3;
        funct7_i    = f7;
        imm_i       = imm;
    endtask

    task automatic idle();
        req_valid_i = 1'b0;
        addr_clr_i  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cycle();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: rand_imm = r;
            1: rand_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            2: rand_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            3: rand_imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
            default: rand_imm = (r & 32'hFFFF_F000) | (($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0);
        endcase
    endfunction

    initial begin
        logic [31:0] held;

        reset         = 1'b1;
        instr_ready_i = 1'b1;
        idle();
        drive(3'd0, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        req_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_valid = 0; m_instr = 0; m_err = 0; m_addr = 0; m_cnt = 0;
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_addr", 32'(instr_addr_o), 32'd0);
        check("rst_cnt", 32'(err_cnt_o), 32'd0);
        reset = 1'b0;

        // Directed encodings from the reference examples.
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        cycle();
        check("i_word", instr_o, 32'h0050_0093);
        check("i_err", 32'(err_o), 32'd0);
        check("i_addr", 32'(instr_addr_o), 32'd0);
        drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8);
        cycle();
        check("b_word", instr_o, 32'hFE20_8CE3);
        drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
        cycle();
        check("j_word", instr_o, 32'h0100_00EF);
        drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        cycle();
        check("u_word", instr_o, 32'h1234_52B7);
        check("u_err", 32'(err_o), 32'd0);
        drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        cycle();
        check("u_bad_err", 32'(err_o), 32'd1);
        idle();
        cycle();
        check("u_bad_cnt", 32'(err_cnt_o), 32'd1);

        // Back-pressure: word held three cycles while a new request waits.
        drive(3'd2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'hFFFF_FFFC);
        instr_ready_i = 1'b0;
        cycle();
        held = instr_o;
        drive(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd1, 7'h20, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_instr", instr_o, held);
            check("hold_ready", 32'(req_ready_o), 32'd0);
        end
        // Clear while held re-tags the held word.
        addr_clr_i = 1'b1;
        cycle();
        check("clr_held_addr", 32'(instr_addr_o), 32'd0);
        check("clr_held_instr", instr_o, held);
        addr_clr_i    = 1'b0;
        instr_ready_i = 1'b1;
        cycle();
        idle();
        cycle();

        // Address wrap with ADDR_W=2 over five back-to-back words.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3'd1, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            cycle();
            check("wrap_addr", 32'(instr_addr_o), 32'(i % 4));
        end
        drive(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        cycle();
        check("pre_clr_addr", 32'(instr_addr_o), 32'd1);
        addr_clr_i = 1'b1;
        cycle();
        check("clr_hs_addr", 32'(instr_addr_o), 32'd0);
        addr_clr_i = 1'b0;

        // Oversized I immediate, then reset while the bad word is held.
        drive(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        cycle();
        check("i800_err", 32'(err_o), 32'd1);
        check("i800_imm", 32'(instr_o[31:20]), 32'h800);
        instr_ready_i = 1'b0;
        idle();
        cycle();
        do_reset();
        check("rst_held_valid", 32'(instr_valid_o), 32'd0);
        check("rst_held_cnt", 32'(err_cnt_o), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 199) == 0);
            addr_clr_i    = ($urandom_range(0, 29) == 0);
            instr_ready_i = ($urandom_range(0, 9) < 7);
            req_valid_i   = ($urandom_range(0, 9) < 7);
            fmt_i         = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7))
                                                          : 3'($urandom_range(0, 5));
            op_i          = 7'($urandom);
            if ($urandom_range(0, 7) != 0) op_i[1:0] = 2'b11;
            rd_i          = 5'($urandom);
            rs1_i         = 5'($urandom);
            rs2_i         = 5'($urandom);
            funct3_i      = 3'($urandom);
            funct7_i      = 7'($urandom);
            imm_i         = rand_imm();
            cycle();
        end
        reset      = 1'b0;
        addr_clr_i = 1'b0;

        // Error counter saturation.
        do_reset();
        instr_ready_i = 1'b1;
        for (int i = 0; i < 262; i++) begin
            drive(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
            cycle();
        end
        check("sat_instr", instr_o, 32'd0);
        check("sat_cnt", 32'(err_cnt_o), 32'd255);
        idle();
        cycle();
        check("sat_hold_cnt", 32'(err_cnt_o), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
